// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg
//   Shared constants for the iterative multiply/divide unit: datapath and
//   register-index widths, iteration-counter width and the op encodings
//   seen on the 'op' port.
//   md_result() picks the half of the datapath that holds the answer.
package mul_div_unit_pkg;

    localparam int WORD_SIZE = 32;
    localparam int REG_INDEX = 5;

    // One spare bit so the counter can reach WORD_SIZE without wrapping
    localparam int CNT_W = $clog2(WORD_SIZE) + 1;

    localparam logic [1:0] MD_OP_MUL  = 2'b00;
    localparam logic [1:0] MD_OP_MULH = 2'b01;
    localparam logic [1:0] MD_OP_DIVU = 2'b10;
    localparam logic [1:0] MD_OP_REMU = 2'b11;

    // The datapath keeps the product high half or the remainder in 'hi'.
    // It keeps the product low half or the quotient in 'lo'.
    // MULH and REMU (op[0]=1) take 'hi'.
    // MUL and DIVU (op[0]=0) take 'lo'.
    function automatic logic [WORD_SIZE-1:0] md_result(
        input logic                 want_hi,
        input logic [WORD_SIZE-1:0] hi,
        input logic [WORD_SIZE-1:0] lo
    );
        return want_hi ? hi : lo;
    endfunction

endpackage

// File: rtl/mul_div_step.sv
// mul_div_step
//   Combinational single iteration of the shared multiply/divide datapath.
//   Ports:
//     is_div   in   1          1 = restoring-divide step, 0 = shift-add multiply step
//     hi_in    in   WORD_SIZE  product high half / partial remainder
//     lo_in    in   WORD_SIZE  multiplier being consumed / dividend becoming quotient
//     operand  in   WORD_SIZE  multiplicand / divisor
//     hi_out   out  WORD_SIZE  updated high half / remainder
//     lo_out   out  WORD_SIZE  updated low half / quotient
module mul_div_step
    import mul_div_unit_pkg::*;
(
    input  logic                 is_div,
    input  logic [WORD_SIZE-1:0] hi_in,
    input  logic [WORD_SIZE-1:0] lo_in,
    input  logic [WORD_SIZE-1:0] operand,
    output logic [WORD_SIZE-1:0] hi_out,
    output logic [WORD_SIZE-1:0] lo_out
);

    logic [WORD_SIZE:0] add_sum;
    logic [WORD_SIZE:0] shifted;
    logic [WORD_SIZE:0] trial;

    // Multiply: add the multiplicand when the multiplier LSB is set, then shift
    // the whole {carry, hi, lo} pair right by one.
    // Divide: bring the next dividend bit into the partial remainder and trial-
    // subtract the divisor. Keep the difference only when it did not go negative.
    // A surviving remainder is always below the divisor, so it fits in WORD_SIZE
    // bits. A zero divisor never goes negative, so the quotient fills with ones
    // and the remainder ends equal to the dividend.
    always_comb begin
        add_sum = {1'b0, hi_in} + {1'b0, operand};
        shifted = {hi_in, lo_in[WORD_SIZE-1]};
        trial   = shifted - {1'b0, operand};
        hi_out  = hi_in;
        lo_out  = lo_in;
        if (is_div) begin
            if (!trial[WORD_SIZE]) begin
                hi_out = trial[WORD_SIZE-1:0];
                lo_out = {lo_in[WORD_SIZE-2:0], 1'b1};
            end else begin
                hi_out = shifted[WORD_SIZE-1:0];
                lo_out = {lo_in[WORD_SIZE-2:0], 1'b0};
            end
        end else if (lo_in[0]) begin
            hi_out = add_sum[WORD_SIZE:1];
            lo_out = {add_sum[0], lo_in[WORD_SIZE-1:1]};
        end else begin
            hi_out = {1'b0, hi_in[WORD_SIZE-1:1]};
            lo_out = {hi_in[0], lo_in[WORD_SIZE-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative unsigned multiply/divide unit between register read and write-back.
//   An accepted op runs WORD_SIZE iterations.
//   It then spends one write-back cycle driving the register-file write port.
//   Ports:
//     clk             in   1          rising-edge clock
//     reset_enable_n  in   1          synchronous active-low reset
//     start           in   1          request, taken only while idle
//     op              in   2          00 MUL, 01 MULH, 10 DIVU, 11 REMU
//     src1_val        in   WORD_SIZE  multiplicand / dividend
//     src2_val        in   WORD_SIZE  multiplier / divisor
//     dest_num        in   REG_INDEX  destination register
//     busy            out  1          op in flight
//     done            out  1          one-cycle pulse in write-back
//     set_num         out  REG_INDEX  register-file write index (held)
//     set_val         out  WORD_SIZE  register-file write data (held)
//     set_enable      out  1          register-file write strobe, never for r0
//   Build option: define MUL_DIV_EARLY_OUT_EN to send ops with a zero operand
//   straight to write-back.
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_enable_n,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WORD_SIZE-1:0] src1_val,
    input  logic [WORD_SIZE-1:0] src2_val,
    input  logic [REG_INDEX-1:0] dest_num,
    output logic                 busy,
    output logic                 done,
    output logic [REG_INDEX-1:0] set_num,
    output logic [WORD_SIZE-1:0] set_val,
    output logic                 set_enable
);

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_WB   = 2'b10
    } md_state_e;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WORD_SIZE - 1);

    md_state_e            state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [WORD_SIZE-1:0] hi_q, hi_d;
    logic [WORD_SIZE-1:0] lo_q, lo_d;
    logic [WORD_SIZE-1:0] operand_q, operand_d;
    logic [1:0]           op_q, op_d;
    logic [REG_INDEX-1:0] dest_q, dest_d;
    logic [REG_INDEX-1:0] set_num_q, set_num_d;
    logic [WORD_SIZE-1:0] set_val_q, set_val_d;
    logic [WORD_SIZE-1:0] step_hi, step_lo;
    logic                 early_out;

`ifdef MUL_DIV_EARLY_OUT_EN
    // A zero operand makes every result a constant, so iterating is pointless
    always_comb begin
        early_out = (src1_val == '0) || (src2_val == '0);
    end
`else
    always_comb begin
        early_out = 1'b0;
    end
`endif

    mul_div_step u_step (
        .is_div  (op_q[1]),
        .hi_in   (hi_q),
        .lo_in   (lo_q),
        .operand (operand_q),
        .hi_out  (step_hi),
        .lo_out  (step_lo)
    );

    // State register plus all datapath registers; reset drops any op in flight
    always_ff @(posedge clk) begin
        if (!reset_enable_n) begin
            state_q   <= MD_IDLE;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            operand_q <= '0;
            op_q      <= '0;
            dest_q    <= '0;
            set_num_q <= '0;
            set_val_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            operand_q <= operand_d;
            op_q      <= op_d;
            dest_q    <= dest_d;
            set_num_q <= set_num_d;
            set_val_q <= set_val_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (start) state_d = early_out ? MD_WB : MD_RUN;
            MD_RUN:  if (count_q == LAST_STEP) state_d = MD_WB;
            MD_WB:   state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // Datapath: latch the request, iterate, then load the write-port registers.
    // The load happens on the same edge that enters write-back, so set_num and
    // set_val are valid for that cycle and hold afterwards.
    always_comb begin
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        operand_d = operand_q;
        op_d      = op_q;
        dest_d    = dest_q;
        set_num_d = set_num_q;
        set_val_d = set_val_q;
        if (state_q == MD_IDLE && start) begin
            op_d    = op;
            dest_d  = dest_num;
            count_d = '0;
            hi_d    = '0;
            if (op[1]) begin
                lo_d      = src1_val;
                operand_d = src2_val;
            end else begin
                lo_d      = src2_val;
                operand_d = src1_val;
            end
            if (early_out) begin
                // Divide by zero: quotient all-ones, remainder is the dividend.
                // Any other zero operand yields zero.
                if (op[1] && src2_val == '0) begin
                    hi_d = src1_val;
                    lo_d = '1;
                end else begin
                    lo_d = '0;
                end
                set_num_d = dest_num;
                set_val_d = md_result(op[0], hi_d, lo_d);
            end
        end else if (state_q == MD_RUN) begin
            hi_d    = step_hi;
            lo_d    = step_lo;
            count_d = count_q + CNT_W'(1);
            if (count_q == LAST_STEP) begin
                set_num_d = dest_q;
                set_val_d = md_result(op_q[0], step_hi, step_lo);
            end
        end else if (state_q == MD_WB) begin
            count_d = '0;
        end
    end

    // Outputs decoded from state; r0 is never written
    always_comb begin
        busy       = (state_q != MD_IDLE);
        done       = (state_q == MD_WB);
        set_enable = (state_q == MD_WB) && (dest_q != '0);
        set_num    = set_num_q;
        set_val    = set_val_q;
    end

endmodule
